// File: rtl/unpacker_pkg.sv
// unpacker_pkg: shared helpers for the unpacker width converter.
package unpacker_pkg;

    // Counter width for n elements; a 1-bit minimum keeps n<=2 legal.
    function automatic int elem_count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/unpacker_cnt.sv
// unpacker_cnt: element index counter with clear, increment and wrap at max.
module unpacker_cnt
    import unpacker_pkg::*;
#(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               clear_i,
    input  logic               incr_i,
    input  logic [width_p-1:0] max_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    // Wrapping at max keeps a non-power-of-two count from reaching max+1.
    always_comb count_d = clear_i ? '0
                        : incr_i  ? ((count_q == max_i) ? '0 : count_q + width_p'(1))
                        : count_q;

    always_ff @(posedge clk_i or negedge reset_ni)
        if (!reset_ni) count_q <= '0;
        else           count_q <= count_d;

    assign count_o = count_q;

endmodule

// File: rtl/unpacker.sv
// unpacker: splits each packed word into packed_num_p elements, one per handshake.
module unpacker
    import unpacker_pkg::*;
#(
    parameter int unpacked_width_p = 2,
    parameter int packed_num_p     = 4,
    parameter int packed_width_p   = unpacked_width_p * packed_num_p,
    parameter bit msb_first_p      = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic [packed_width_p-1:0]   packed_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [unpacked_width_p-1:0] unpacked_o,
    output logic                        valid_o,
    output logic                        last_o,
    input  logic                        ready_i
);

    localparam int cw_lp = elem_count_width(packed_num_p);

    logic [packed_width_p-1:0] data_q, data_d;
    logic                      full_q, full_d;
    logic [cw_lp-1:0]          cnt_q;
    logic                      in_fire, out_fire, drain;

    assign last_o     = full_q & (cnt_q == cw_lp'(packed_num_p - 1));
    assign valid_o    = full_q;
    // ready_i feeds ready_o directly so a new word loads as the last element leaves.
    assign ready_o    = ~full_q | (last_o & ready_i);
    assign unpacked_o = msb_first_p ? data_q[packed_width_p-1 -: unpacked_width_p]
                                    : data_q[unpacked_width_p-1:0];

    assign in_fire  = valid_i & ready_o;
    assign out_fire = full_q & ready_i;
    assign drain    = out_fire & last_o;

    always_comb begin
        data_d = in_fire                ? packed_i
               : drain                  ? '0
               : out_fire & msb_first_p ? data_q << unpacked_width_p
               : out_fire               ? data_q >> unpacked_width_p
               : data_q;
        full_d = in_fire ? 1'b1 : drain ? 1'b0 : full_q;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    unpacker_cnt #(.width_p(cw_lp)) u_cnt (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .clear_i (in_fire | drain),
        .incr_i  (out_fire & ~last_o),
        .max_i   (cw_lp'(packed_num_p - 1)),
        .count_o (cnt_q)
    );

endmodule

// File: tb/tb_unpacker.sv
// tb_unpacker: directed vector table plus hand sequences for reset and MSB-first 4/3.
module tb_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  a_pk;
    logic        a_vi, a_ri, a_ro, a_vo, a_lo;
    logic [1:0]  a_uo;
    logic [11:0] b_pk;
    logic        b_vi, b_ri, b_ro, b_vo, b_lo;
    logic [3:0]  b_uo;

    int total = 0;
    int bad   = 0;

    unpacker dut_a (
        .clk_i(clk), .reset_ni(rst_n), .packed_i(a_pk), .valid_i(a_vi), .ready_o(a_ro),
        .unpacked_o(a_uo), .valid_o(a_vo), .last_o(a_lo), .ready_i(a_ri)
    );

    unpacker #(.unpacked_width_p(4), .packed_num_p(3), .msb_first_p(1'b1)) dut_b (
        .clk_i(clk), .reset_ni(rst_n), .packed_i(b_pk), .valid_i(b_vi), .ready_o(b_ro),
        .unpacked_o(b_uo), .valid_o(b_vo), .last_o(b_lo), .ready_i(b_ri)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] p;
        logic       r;
        logic       ev;
        logic [1:0] ed;
        logic       el;
        logic       er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [7:0] p, logic r, logic ev, logic [1:0] ed,
                                logic el, logic er);
        vec_t t;
        t.v = v; t.p = p; t.r = r; t.ev = ev; t.ed = ed; t.el = el; t.er = er;
        return t;
    endfunction

    initial begin
        logic [3:0] b_exp [6];
        logic [1:0] m_exp [4];
        b_exp = '{4'hA, 4'hB, 4'hC, 4'h5, 4'h6, 4'h7};
        m_exp = '{2'd3, 2'd2, 2'd1, 2'd0};

        // back-to-back E4 then 1B, then idle
        tbl.push_back(mk(1, 8'hE4, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 8'h1B, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h1B, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'h1B, 1, 1, 2, 0, 0));
        tbl.push_back(mk(1, 8'h1B, 1, 1, 3, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 3, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 2, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1));
        // backpressure on element 1, pending word AA must wait
        tbl.push_back(mk(1, 8'hE4, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 8'hAA, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hAA, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'hAA, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'hAA, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'hAA, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'hAA, 1, 1, 2, 0, 0));
        tbl.push_back(mk(1, 8'hAA, 0, 1, 3, 1, 0));
        tbl.push_back(mk(1, 8'hAA, 1, 1, 3, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 2, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 2, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 2, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 2, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1));

        // reset held with traffic offered
        rst_n = 1'b0; a_vi = 1'b1; a_ri = 1'b1; a_pk = 8'hE4;
        b_vi = 1'b0; b_ri = 1'b1; b_pk = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", a_vo, 0);
            chk("rst_ready", a_ro, 1);
            chk("rst_data", a_uo, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            a_vi = tbl[i].v; a_pk = tbl[i].p; a_ri = tbl[i].r;
            @(negedge clk);
            chk($sformatf("t%0d_valid", i), a_vo, tbl[i].ev);
            chk($sformatf("t%0d_data", i), a_uo, tbl[i].ed);
            chk($sformatf("t%0d_last", i), a_lo, tbl[i].el);
            chk($sformatf("t%0d_ready", i), a_ro, tbl[i].er);
            @(posedge clk); #1;
        end

        // asynchronous reset while element 1 of E4 is shown
        a_vi = 1'b1; a_pk = 8'hE4; a_ri = 1'b1;
        @(posedge clk); #1;
        a_vi = 1'b0;
        @(posedge clk); #1;
        chk("mid_elem1", a_uo, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_valid", a_vo, 0);
        chk("mid_async_ready", a_ro, 1);
        chk("mid_async_data", a_uo, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_vi = 1'b1; a_pk = 8'h1B;
        @(negedge clk);
        chk("post_rst_valid", a_vo, 0);
        @(posedge clk); #1;
        a_vi = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_e%0d", k), a_uo, m_exp[k]);
            chk($sformatf("post_rst_l%0d", k), a_lo, k == 3);
            @(posedge clk); #1;
        end
        chk("post_rst_idle", a_vo, 0);

        // MSB-first 4/3: ABC then 567 back-to-back
        b_vi = 1'b1; b_pk = 12'hABC;
        @(posedge clk); #1;
        b_pk = 12'h567;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("msb_v%0d", k), b_vo, 1);
            chk($sformatf("msb_e%0d", k), b_uo, b_exp[k]);
            chk($sformatf("msb_l%0d", k), b_lo, (k == 2) || (k == 5));
            chk($sformatf("msb_cnt%0d", k), dut_b.cnt_q <= 2'd2, 1);
            @(posedge clk); #1;
            if (k == 2) b_vi = 1'b0;
        end
        @(negedge clk);
        chk("msb_idle", b_vo, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
